rx_seq_checker: RTL and testbench
=================================

# rx_seq_checker

Sequence checker sitting directly downstream of the receiver in the transmit/receive system. It samples each 12-bit word the receiver validates while the converters are enabled and checks that successive words follow the transmitter's free-running counter, i.e. each word is the previous one plus 1, modulo 2^WIDTH. It reports lock status and counts accepted words and sequence errors for the bench and for system-level status readout.

## Interface
- WIDTH, 12: data word width; must match the receiver's data width.
- LOCK_CNT, 4: consecutive in-sequence words needed to declare lock; minimum 1.
- LOSS_CNT, 3: consecutive errors while locked that drop lock; minimum 1.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- conv_en_n  in  1  active-low converter enable; words are ignored while high.
- data_in  in  WIDTH  received data word.
- data_valid  in  1  receiver valid strobe, one cycle per word.
- clr_stats  in  1  synchronous clear of word_cnt and err_cnt.
- locked  out  1  high in states LOCKED and SLIP.
- err_pulse  out  1  one-cycle pulse per counted sequence error.
- word_cnt  out  CNT_W  accepted words, saturating.
- err_cnt  out  CNT_W  counted sequence errors, saturating.
- expected  out  WIDTH  next expected word.
- state  out  2  SEARCH=0, ACQUIRE=1, LOCKED=2, SLIP=3.

## Operation
- accept = data_valid & ~conv_en_n. The block only changes state, expected or the counters on an accept cycle. When conv_en_n is high, state and expected hold.
- match = (data_in == expected). All increments are modulo 2^WIDTH, so 4095 followed by 0 is in sequence.
- Internal counters: run (consecutive matches, sized for LOCK_CNT) and miss (consecutive errors, sized for LOSS_CNT).
- SEARCH, on accept:
  - expected <= data_in+1 and run <= 1.
  - Go to LOCKED if LOCK_CNT==1, otherwise to ACQUIRE.
- ACQUIRE, on accept:
  - Match: expected <= data_in+1 and run++. When run reaches LOCK_CNT, go to LOCKED.
  - Mismatch: resync with expected <= data_in+1 and run <= 1, and stay in ACQUIRE.
  - No error is counted in ACQUIRE.
- LOCKED, on accept:
  - Match: expected++.
  - Mismatch: count an error, expected <= expected+1 (flywheel, no resync) and miss <= 1. Go to SLIP, or to ACQUIRE resynced on data_in (run <= 1, expected <= data_in+1) if LOSS_CNT==1.
- SLIP, on accept:
  - Match: expected++, miss <= 0, go to LOCKED.
  - Mismatch: count an error and miss++. If miss reaches LOSS_CNT, go to ACQUIRE resynced on data_in. Otherwise expected++ and stay in SLIP.
- Counting an error means err_pulse = 1 on the next cycle and err_cnt++.
- word_cnt++ on every accept, in every state.
- Both counters saturate at all-ones and do not wrap.
- clr_stats zeroes word_cnt and err_cnt. If clr_stats coincides with an accept, the clear wins and both counters read 0. clr_stats does not affect state, expected or err_pulse.
- rst overrides everything, including mid-operation.

## Timing
- Every output is registered. All outputs update on the same rising edge that samples the accepted word, so results are visible one cycle after data_valid is presented.
- err_pulse is high for exactly one cycle per counted error. Back-to-back errors on consecutive cycles give a continuous high.
- Accepts may arrive every cycle; there is no back-pressure.
- Reset values, one cycle after rst is sampled high:
  - state = SEARCH, locked = 0, err_pulse = 0.
  - word_cnt = 0, err_cnt = 0, expected = 0.
  - run = 0, miss = 0.
- A word accepted in the same cycle that rst is high is dropped.

## Test plan
All scenarios use the default parameters.
- Acquire: after rst, accept 10, 11, 12, 13 on consecutive cycles. Required: state 1 after the first edge, locked = 1 after the fourth edge, expected = 14, word_cnt = 4, err_cnt = 0.
- Wrap: while locked with expected = 4094, accept 4094, 4095, 0, 1. Required: no err_pulse, expected = 2, locked stays 1.
- Single slip: while locked at expected = 20, accept 99, then 21. Required: err_pulse for 1 cycle, err_cnt = 1, state 3 then 2, locked stays 1 throughout, expected = 22.
- Loss: while locked at expected = 20, accept 50, 60, 70. Required: err_cnt = 3, locked falls after the third edge, state = 1, expected = 71.
- Gating and clear: hold conv_en_n = 1 and pulse data_valid 5 times. Required: word_cnt, state and expected unchanged. Then assert clr_stats together with an accepted word. Required: word_cnt = 0 and err_cnt = 0.
- Reset mid-lock: assert rst for 1 cycle while locked with err_cnt = 2. Required: next cycle state = 0, locked = 0, both counters 0, expected = 0.

Source files
------------

// File: rtl/rx_seq_checker.sv
// Receive-side sequence checker: tracks the transmitter's free-running counter,
// reports lock, and keeps saturating word and error statistics.
module rx_seq_checker #(
  parameter int WIDTH    = 12,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             conv_en_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  input  logic             clr_stats,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] expected,
  output logic [1:0]       state
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    SLIP    = 2'd3
  } state_t;

  state_t              state_q;
  logic [RUN_W-1:0]    run;
  logic [MISS_W-1:0]   miss;
  logic                accept;
  logic                match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
    return v + 1'b1;
  endfunction

  assign accept = data_valid & ~conv_en_n;
  assign match  = (data_in == expected);
  assign state  = state_q;

  // Stage 0: sample the accepted word and update FSM, tracker and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEARCH;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      word_cnt  <= '0;
      err_cnt   <= '0;
      expected  <= '0;
      run       <= '0;
      miss      <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (accept) begin
        word_cnt <= sat_inc(word_cnt);
        case (state_q)
          SEARCH: begin
            expected <= wrap_inc(data_in);
            run      <= RUN_W'(1);
            if (LOCK_CNT == 1) begin
              state_q <= LOCKED;
              locked  <= 1'b1;
            end else begin
              state_q <= ACQUIRE;
              locked  <= 1'b0;
            end
          end
          ACQUIRE: begin
            expected <= wrap_inc(data_in);
            if (match) begin
              run <= run + 1'b1;
              if (run + 1'b1 == RUN_W'(LOCK_CNT)) begin
                state_q <= LOCKED;
                locked  <= 1'b1;
              end
            end else begin
              run <= RUN_W'(1);
            end
          end
          LOCKED: begin
            if (match) begin
              expected <= wrap_inc(expected);
            end else begin
              err_pulse <= 1'b1;
              err_cnt   <= sat_inc(err_cnt);
              miss      <= MISS_W'(1);
              if (LOSS_CNT == 1) begin
                state_q  <= ACQUIRE;
                locked   <= 1'b0;
                run      <= RUN_W'(1);
                expected <= wrap_inc(data_in);
              end else begin
                state_q  <= SLIP;
                expected <= wrap_inc(expected);
              end
            end
          end
          SLIP: begin
            if (match) begin
              expected <= wrap_inc(expected);
              miss     <= '0;
              state_q  <= LOCKED;
            end else begin
              err_pulse <= 1'b1;
              err_cnt   <= sat_inc(err_cnt);
              miss      <= miss + 1'b1;
              // Too many consecutive misses: give up the flywheel and resync
              if (miss + 1'b1 == MISS_W'(LOSS_CNT)) begin
                state_q  <= ACQUIRE;
                locked   <= 1'b0;
                run      <= RUN_W'(1);
                expected <= wrap_inc(data_in);
              end else begin
                expected <= wrap_inc(expected);
              end
            end
          end
          default: begin
            state_q <= SEARCH;
            locked  <= 1'b0;
          end
        endcase
      end
      if (clr_stats) begin
        word_cnt <= '0;
        err_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rx_seq_checker.sv
// Directed bench for rx_seq_checker: acquisition, wrap, slip, loss, gating,
// statistics clear and mid-lock reset, with hand-computed expectations.
module tb_rx_seq_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        conv_en_n;
  logic [11:0] data_in;
  logic        data_valid;
  logic        clr_stats;
  logic        locked;
  logic        err_pulse;
  logic [15:0] word_cnt;
  logic [15:0] err_cnt;
  logic [11:0] expected;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  rx_seq_checker dut (
    .clk        (clk),
    .rst        (rst),
    .conv_en_n  (conv_en_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .clr_stats  (clr_stats),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .word_cnt   (word_cnt),
    .err_cnt    (err_cnt),
    .expected   (expected),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] d);
    data_in    = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic lock_at(input logic [11:0] first);
    do_reset();
    for (int i = 0; i < 4; i++) send(first + 12'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; conv_en_n = 1'b0; data_in = '0; data_valid = 1'b0; clr_stats = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_state", 32'(state), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_err_pulse", 32'(err_pulse), 0);
    check("rst_word_cnt", 32'(word_cnt), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_expected", 32'(expected), 0);

    // Acquire
    send(12'd10);
    check("acq_state1", 32'(state), 1);
    check("acq_exp1", 32'(expected), 11);
    send(12'd11);
    send(12'd12);
    check("acq_locked3", 32'(locked), 0);
    send(12'd13);
    check("acq_locked", 32'(locked), 1);
    check("acq_state", 32'(state), 2);
    check("acq_expected", 32'(expected), 14);
    check("acq_word_cnt", 32'(word_cnt), 4);
    check("acq_err_cnt", 32'(err_cnt), 0);

    // Wrap through 4095 -> 0
    lock_at(12'd4090);
    check("wrap_pre_exp", 32'(expected), 4094);
    send(12'd4094); check("wrap_ep0", 32'(err_pulse), 0);
    send(12'd4095); check("wrap_ep1", 32'(err_pulse), 0);
    send(12'd0);    check("wrap_ep2", 32'(err_pulse), 0);
    send(12'd1);    check("wrap_ep3", 32'(err_pulse), 0);
    check("wrap_expected", 32'(expected), 2);
    check("wrap_locked", 32'(locked), 1);
    check("wrap_err_cnt", 32'(err_cnt), 0);

    // Single slip
    lock_at(12'd16);
    check("slip_pre_exp", 32'(expected), 20);
    send(12'd99);
    check("slip_ep", 32'(err_pulse), 1);
    check("slip_state3", 32'(state), 3);
    check("slip_locked_a", 32'(locked), 1);
    check("slip_err_cnt", 32'(err_cnt), 1);
    check("slip_exp_a", 32'(expected), 21);
    send(12'd21);
    check("slip_ep_off", 32'(err_pulse), 0);
    check("slip_state2", 32'(state), 2);
    check("slip_locked_b", 32'(locked), 1);
    check("slip_expected", 32'(expected), 22);
    check("slip_err_cnt_b", 32'(err_cnt), 1);

    // Loss of lock
    lock_at(12'd16);
    send(12'd50);
    check("loss_state_a", 32'(state), 3);
    check("loss_exp_a", 32'(expected), 21);
    send(12'd60);
    check("loss_ep_b", 32'(err_pulse), 1);
    check("loss_locked_b", 32'(locked), 1);
    check("loss_exp_b", 32'(expected), 22);
    send(12'd70);
    check("loss_ep_c", 32'(err_pulse), 1);
    check("loss_err_cnt", 32'(err_cnt), 3);
    check("loss_locked", 32'(locked), 0);
    check("loss_state", 32'(state), 1);
    check("loss_expected", 32'(expected), 71);
    check("loss_word_cnt", 32'(word_cnt), 7);
    tick();
    check("loss_ep_off", 32'(err_pulse), 0);

    // Gating, then clear coincident with an accept
    conv_en_n = 1'b1;
    for (int i = 0; i < 5; i++) send(12'(71 + i));
    check("gate_word_cnt", 32'(word_cnt), 7);
    check("gate_state", 32'(state), 1);
    check("gate_expected", 32'(expected), 71);
    conv_en_n = 1'b0;
    clr_stats = 1'b1;
    send(12'd71);
    clr_stats = 1'b0;
    check("clr_word_cnt", 32'(word_cnt), 0);
    check("clr_err_cnt", 32'(err_cnt), 0);
    check("clr_state", 32'(state), 1);
    check("clr_expected", 32'(expected), 72);
    send(12'd72);
    check("post_clr_word_cnt", 32'(word_cnt), 1);

    // Reset mid-lock with err_cnt = 2; the word presented with rst is dropped
    lock_at(12'd16);
    send(12'd99);
    send(12'd21);
    send(12'd99);
    send(12'd23);
    check("ml_state", 32'(state), 2);
    check("ml_err_cnt", 32'(err_cnt), 2);
    rst = 1'b1;
    send(12'd24);
    rst = 1'b0;
    check("mr_state", 32'(state), 0);
    check("mr_locked", 32'(locked), 0);
    check("mr_word_cnt", 32'(word_cnt), 0);
    check("mr_err_cnt", 32'(err_cnt), 0);
    check("mr_expected", 32'(expected), 0);
    tick();
    check("mr_hold_state", 32'(state), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
